// File: rtl/feature_map_streamer_if.sv
// rtl/feature_map_streamer_if.sv - pixel capture input, dense raster output and status signals
interface feature_map_streamer_if #(
  parameter int D = 8
);
  logic [D-1:0] d_in;
  logic         v_in;
  logic [D-1:0] d_out;
  logic         v_out;
  logic         out_ready;
  logic         row_last;
  logic         frame_last;
  logic         frame_done;
  logic         busy;
  logic         overflow;

  modport master (
    output d_in, v_in, out_ready,
    input  d_out, v_out, row_last, frame_last, frame_done, busy, overflow
  );

  modport slave (
    input  d_in, v_in, out_ready,
    output d_out, v_out, row_last, frame_last, frame_done, busy, overflow
  );
endinterface

// File: rtl/feature_map_streamer.sv
// rtl/feature_map_streamer.sv - captures one W x H feature map, replays it as a dense raster stream
// FMS_ROW_GAP_EN adds GAP idle cycles after every row but the last.
module feature_map_streamer #(
  parameter int W   = 24,
  parameter int H   = 24,
  parameter int D   = 8,
  parameter int GAP = 4
) (
  input logic                   clk,
  input logic                   rst_n,
  feature_map_streamer_if.slave io
);
  localparam int N  = W * H;
  localparam int AW = (N > 1) ? $clog2(N) : 1;
  localparam int XW = (W > 1) ? $clog2(W) : 1;
  localparam int YW = (H > 1) ? $clog2(H) : 1;
  localparam logic [AW-1:0] A_LAST = AW'(N - 1);
  localparam logic [XW-1:0] X_LAST = XW'(W - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(H - 1);

`ifdef FMS_ROW_GAP_EN
  localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;
  localparam logic [GW-1:0] G_LAST = GW'(GAP - 1);
  typedef enum logic [1:0] {S_FILL = 2'd0, S_DRAIN = 2'd1, S_GAP = 2'd2} state_t;
  logic [GW-1:0] gap_q, gap_d;
`else
  typedef enum logic [1:0] {S_FILL = 2'd0, S_DRAIN = 2'd1} state_t;
`endif

  state_t        state_q, state_d;
  logic [AW-1:0] wa_q, wa_d;
  logic [AW-1:0] ra_q, ra_d;
  logic          rd_done_q, rd_done_d;
  logic [XW-1:0] x_q, x_d;
  logic [YW-1:0] y_q, y_d;
  logic          rvalid_q, rvalid_d;
  logic [D-1:0]  sk0_q, sk0_d;
  logic [D-1:0]  sk1_q, sk1_d;
  logic [1:0]    cnt_q, cnt_d;
  logic          frame_done_q, frame_done_d;
  logic          overflow_q, overflow_d;

  logic [D-1:0]  mem [N];
  logic [D-1:0]  rd_data_q;
  logic          we, re;
  logic          v_out_w, acc, row_last_w, frame_last_w;
  logic [D-1:0]  head;
  logic [1:0]    occ;

  // The head pixel comes from the skid when it holds anything, else straight from the RAM read register.
  always_comb begin
    v_out_w      = (state_q == S_DRAIN) && ((cnt_q != 2'd0) || rvalid_q);
    head         = (cnt_q != 2'd0) ? sk0_q : rd_data_q;
    row_last_w   = (x_q == X_LAST);
    frame_last_w = row_last_w && (y_q == Y_LAST);
    acc          = v_out_w && io.out_ready;
    occ          = cnt_q + {1'b0, rvalid_q};
  end

  assign io.d_out      = v_out_w ? head : '0;
  assign io.v_out      = v_out_w;
  assign io.row_last   = v_out_w && row_last_w;
  assign io.frame_last = v_out_w && frame_last_w;
  assign io.frame_done = frame_done_q;
  assign io.busy       = (state_q != S_FILL) || (wa_q != '0);
  assign io.overflow   = overflow_q;

  always_comb begin
    logic [1:0] c;
    state_d      = state_q;
    wa_d         = wa_q;
    ra_d         = ra_q;
    rd_done_d    = rd_done_q;
    x_d          = x_q;
    y_d          = y_q;
    sk0_d        = sk0_q;
    sk1_d        = sk1_q;
    frame_done_d = 1'b0;
    overflow_d   = overflow_q || (io.v_in && (state_q != S_FILL));
    we           = 1'b0;
    re           = 1'b0;
    c            = cnt_q;
`ifdef FMS_ROW_GAP_EN
    gap_d        = gap_q;
`endif

    if (state_q == S_FILL && io.v_in) begin
      we = 1'b1;
      if (wa_q == A_LAST) begin
        wa_d    = '0;
        state_d = S_DRAIN;
      end else begin
        wa_d = wa_q + AW'(1);
      end
    end

    // Issue a read only if the skid can still absorb it once in-flight data lands.
    if (state_q != S_FILL && !rd_done_q && ((occ != 2'd2) || acc)) begin
      re = 1'b1;
      if (ra_q == A_LAST) begin
        ra_d      = '0;
        rd_done_d = 1'b1;
      end else begin
        ra_d = ra_q + AW'(1);
      end
    end
    rvalid_d = re;

    if (acc && cnt_q != 2'd0) begin
      sk0_d = sk1_q;
      c     = c - 2'd1;
    end
    if (rvalid_q && !(acc && cnt_q == 2'd0)) begin
      if (c == 2'd0) sk0_d = rd_data_q;
      else           sk1_d = rd_data_q;
      c = c + 2'd1;
    end
    cnt_d = c;

    if (acc) begin
      if (frame_last_w) begin
        x_d          = '0;
        y_d          = '0;
        rd_done_d    = 1'b0;
        state_d      = S_FILL;
        frame_done_d = 1'b1;
      end else if (row_last_w) begin
        x_d = '0;
        y_d = y_q + YW'(1);
`ifdef FMS_ROW_GAP_EN
        state_d = S_GAP;
        gap_d   = '0;
`endif
      end else begin
        x_d = x_q + XW'(1);
      end
    end

`ifdef FMS_ROW_GAP_EN
    if (state_q == S_GAP) begin
      if (gap_q == G_LAST) state_d = S_DRAIN;
      else                 gap_d   = gap_q + GW'(1);
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (we) mem[wa_q] <= io.d_in;
    if (re) rd_data_q <= mem[ra_q];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_FILL;
      wa_q         <= '0;
      ra_q         <= '0;
      rd_done_q    <= 1'b0;
      x_q          <= '0;
      y_q          <= '0;
      rvalid_q     <= 1'b0;
      sk0_q        <= '0;
      sk1_q        <= '0;
      cnt_q        <= 2'd0;
      frame_done_q <= 1'b0;
      overflow_q   <= 1'b0;
`ifdef FMS_ROW_GAP_EN
      gap_q        <= '0;
`endif
    end else begin
      state_q      <= state_d;
      wa_q         <= wa_d;
      ra_q         <= ra_d;
      rd_done_q    <= rd_done_d;
      x_q          <= x_d;
      y_q          <= y_d;
      rvalid_q     <= rvalid_d;
      sk0_q        <= sk0_d;
      sk1_q        <= sk1_d;
      cnt_q        <= cnt_d;
      frame_done_q <= frame_done_d;
      overflow_q   <= overflow_d;
`ifdef FMS_ROW_GAP_EN
      gap_q        <= gap_d;
`endif
    end
  end
endmodule
